// File: rtl/axis_row_pack_fifo.sv
// Packs AXI4-Stream element beats into MAC-width rows and buffers up to DEPTH
// complete rows. A row commits on its latched element count or on tlast.
module axis_row_pack_fifo #(
    parameter int DATA_W  = 32,
    parameter int ELEM_W  = 5,
    parameter int LANES   = 6,
    parameter int MAC_NUM = 256,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_W-1:0]         s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    input  logic [11:0]               row_len,
    input  logic                      clear,
    output logic [ELEM_W*MAC_NUM-1:0] m_row_data,
    output logic                      m_row_valid,
    input  logic                      m_row_ready,
    output logic                      m_row_last,
    output logic [CNT_W-1:0]          fifo_cnt,
    output logic                      fifo_empty,
    output logic                      fifo_full,
    output logic                      pack_busy
);
    localparam int ROW_W = ELEM_W * MAC_NUM;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LEN_W = 12;
    localparam logic [LEN_W-1:0] MAC_LEN = LEN_W'(MAC_NUM);

    logic [ROW_W-1:0] slots [DEPTH];
    logic [DEPTH-1:0] last_q;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LEN_W-1:0] pack_idx;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] len_cur;
    logic [ROW_W-1:0] row_next;
    logic             accept;
    logic             pop;
    logic             commit;

    // The first beat of a row uses the live length; later beats use the latched one.
    assign len_eff = (row_len == '0 || row_len > MAC_LEN) ? MAC_LEN : row_len;
    assign len_cur = (pack_idx == '0) ? len_eff : len_q;

    assign fifo_empty    = (fifo_cnt == '0);
    assign fifo_full     = (fifo_cnt == CNT_W'(DEPTH));
    assign pack_busy     = (pack_idx != '0);
    assign s_axis_tready = !fifo_full && !clear;
    assign m_row_valid   = !fifo_empty;
    assign m_row_data    = slots[rd_ptr];
    assign m_row_last    = last_q[rd_ptr];

    assign accept = s_axis_tvalid && s_axis_tready;
    assign pop    = m_row_valid && m_row_ready && !clear;
    assign commit = accept && (s_axis_tlast || (int'(pack_idx) + LANES >= int'(len_cur)));

    // NOTE: row_next gets its full default before the lane overlay, so no latch is inferred.
    always_comb begin
        row_next = (pack_idx == '0) ? '0 : slots[wr_ptr];
        for (int k = 0; k < LANES; k++) begin
            if (int'(pack_idx) + k < MAC_NUM) begin
                row_next[(int'(pack_idx) + k) * ELEM_W +: ELEM_W] =
                    (int'(pack_idx) + k < int'(len_cur)) ? s_axis_tdata[k*ELEM_W +: ELEM_W] : '0;
            end
        end
    end

    // NOTE: row storage is reset so the head row reads as zero straight out of reset;
    // clear deliberately leaves it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (accept) begin
            slots[wr_ptr] <= row_next;
        end
    end

    // NOTE: all state below updates with non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pack_idx <= '0;
            len_q    <= '0;
            fifo_cnt <= '0;
            last_q   <= '0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pack_idx <= '0;
            fifo_cnt <= '0;
            last_q   <= '0;
        end else begin
            if (accept) begin
                if (pack_idx == '0) begin
                    len_q <= len_eff;
                end
                if (commit) begin
                    pack_idx       <= '0;
                    wr_ptr         <= wr_ptr + PTR_W'(1);
                    last_q[wr_ptr] <= s_axis_tlast;
                end else begin
                    pack_idx <= pack_idx + LEN_W'(LANES);
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (commit && !pop) begin
                fifo_cnt <= fifo_cnt + CNT_W'(1);
            end else if (pop && !commit) begin
                fifo_cnt <= fifo_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_axis_row_pack_fifo.sv
// Scoreboard bench for axis_row_pack_fifo: a queue-of-elements row model feeds
// expected rows to a monitor that checks every popped row.
module tb_axis_row_pack_fifo;
    localparam int DATA_W  = 32;
    localparam int ELEM_W  = 5;
    localparam int LANES   = 6;
    localparam int MAC_NUM = 256;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ROW_W   = ELEM_W * MAC_NUM;

    typedef struct {
        logic [ROW_W-1:0] data;
        logic             last;
    } row_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              s_axis_tlast;
    logic [11:0]       row_len;
    logic              clear;
    logic [ROW_W-1:0]  m_row_data;
    logic              m_row_valid;
    logic              m_row_ready;
    logic              m_row_last;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_empty;
    logic              fifo_full;
    logic              pack_busy;

    always #5 clk = ~clk;

    axis_row_pack_fifo #(
        .DATA_W(DATA_W), .ELEM_W(ELEM_W), .LANES(LANES), .MAC_NUM(MAC_NUM), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .row_len(row_len), .clear(clear),
        .m_row_data(m_row_data), .m_row_valid(m_row_valid),
        .m_row_ready(m_row_ready), .m_row_last(m_row_last),
        .fifo_cnt(fifo_cnt), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .pack_busy(pack_busy)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    row_t exp_q[$];
    int   cur[$];        // elements received so far for the row in progress
    int   m_len    = 0;
    int   m_wr     = 0;
    int   m_rd     = 0;
    int   pop_mode = 0;  // 0 hold, 1 random, 2 always
    bit   pop_once = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int elem(input int e);
        return int'(m_row_data[e*ELEM_W +: ELEM_W]);
    endfunction

    function automatic logic [DATA_W-1:0] mk(input int base);
        logic [DATA_W-1:0] d = '0;
        for (int k = 0; k < LANES; k++) d[k*ELEM_W +: ELEM_W] = ELEM_W'(base + k);
        return d;
    endfunction

    task automatic model_flush();
        exp_q.delete();
        cur.delete();
        m_wr = 0;
        m_rd = 0;
    endtask

    // Row = first min(len, received) elements of the stream, zeros elsewhere.
    task automatic model_accept(input logic [DATA_W-1:0] d, input logic l);
        row_t r;
        if (cur.size() == 0)
            m_len = (row_len == 0 || int'(row_len) > MAC_NUM) ? MAC_NUM : int'(row_len);
        for (int k = 0; k < LANES; k++) cur.push_back(int'(d[k*ELEM_W +: ELEM_W]));
        if (cur.size() >= m_len || l) begin
            r.data = '0;
            r.last = l;
            for (int e = 0; e < MAC_NUM; e++)
                if (e < m_len && e < cur.size()) r.data[e*ELEM_W +: ELEM_W] = ELEM_W'(cur[e]);
            exp_q.push_back(r);
            cur.delete();
            m_wr = (m_wr + 1) % DEPTH;
        end
    endtask

    task automatic beat(input logic [DATA_W-1:0] d, input logic l);
        int guard = 0;
        @(negedge clk);
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!s_axis_tready) begin
            check("beat_accept_timeout", 0, 1);
            s_axis_tvalid = 1'b0;
            return;
        end
        model_accept(d, l);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        pop_mode = 2;
        while ((!fifo_empty || exp_q.size() != 0) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("drain_empty", int'(fifo_empty), 1);
        check("drain_queue", exp_q.size(), 0);
        pop_mode = 0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_tready"}, int'(s_axis_tready), 1);
        check({tag, "_valid"},  int'(m_row_valid), 0);
        check({tag, "_data0"},  int'(m_row_data == '0), 1);
        check({tag, "_last"},   int'(m_row_last), 0);
        check({tag, "_cnt"},    int'(fifo_cnt), 0);
        check({tag, "_empty"},  int'(fifo_empty), 1);
        check({tag, "_full"},   int'(fifo_full), 0);
        check({tag, "_busy"},   int'(pack_busy), 0);
    endtask

    initial begin : monitor
        row_t e;
        int   bad;
        m_row_ready = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (pop_once) begin
                m_row_ready = 1'b1;
                pop_once    = 1'b0;
            end else if (pop_mode == 2) m_row_ready = 1'b1;
            else if (pop_mode == 1) m_row_ready = 1'($urandom_range(0, 1));
            else m_row_ready = 1'b0;
            if (rst_n && !clear && m_row_valid && m_row_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL row_pop: unexpected row, last=%0d", m_row_last);
                end else begin
                    e = exp_q.pop_front();
                    m_rd = (m_rd + 1) % DEPTH;
                    if (m_row_data === e.data && m_row_last === e.last) begin
                        n_pass++;
                    end else begin
                        bad = 0;
                        for (int i = MAC_NUM - 1; i >= 0; i--)
                            if (m_row_data[i*ELEM_W +: ELEM_W] !== e.data[i*ELEM_W +: ELEM_W]) bad = i;
                        $display("FAIL row_data: element %0d got %0d expected %0d, last got %0d expected %0d",
                                 bad, m_row_data[bad*ELEM_W +: ELEM_W], e.data[bad*ELEM_W +: ELEM_W],
                                 m_row_last, e.last);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [DATA_W-1:0] d;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        row_len       = 12'd12;
        clear         = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset("reset");

        // Two-beat row of 12 elements.
        beat(mk(1), 1'b0);
        @(negedge clk);
        check("two_beat_mid_valid", int'(m_row_valid), 0);
        check("two_beat_mid_busy", int'(pack_busy), 1);
        beat(mk(7), 1'b0);
        @(negedge clk);
        check("two_beat_valid", int'(m_row_valid), 1);
        check("two_beat_last", int'(m_row_last), 0);
        check("two_beat_cnt", int'(fifo_cnt), 1);
        check("two_beat_e0", elem(0), 1);
        check("two_beat_e11", elem(11), 12);
        check("two_beat_e12", elem(12), 0);
        drain();

        // Partial last beat: len 10 of all-ones lanes.
        row_len = 12'd10;
        beat('1, 1'b0);
        beat('1, 1'b0);
        @(negedge clk);
        check("partial_cnt", int'(fifo_cnt), 1);
        check("partial_e9", elem(9), 31);
        check("partial_e10", elem(10), 0);
        check("partial_e11", elem(11), 0);
        drain();

        // Fill to full, hold a fifth beat, recover after one pop.
        row_len = 12'd6;
        repeat (4) beat($urandom, 1'b0);
        @(negedge clk);
        check("full_cnt", int'(fifo_cnt), 4);
        check("full_flag", int'(fifo_full), 1);
        check("full_tready", int'(s_axis_tready), 0);
        fork
            beat($urandom, 1'b0);
            begin
                repeat (2) @(negedge clk);
                check("full_held_tready", int'(s_axis_tready), 0);
                check("full_held_cnt", int'(fifo_cnt), 4);
                check("full_held_busy", int'(pack_busy), 0);
                pop_once = 1'b1;
                @(negedge clk);
                check("full_pop_cnt", int'(fifo_cnt), 3);
                check("full_pop_tready", int'(s_axis_tready), 1);
                @(negedge clk);
                check("full_refill_cnt", int'(fifo_cnt), 4);
            end
        join
        drain();

        // Commit and pop in the same cycle, walking the pointers through a wrap.
        beat($urandom, 1'b0);
        beat($urandom, 1'b0);
        @(negedge clk);
        check("cp_start_cnt", int'(fifo_cnt), 2);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            pop_once = 1'b1;
            beat($urandom, 1'b0);
            @(negedge clk);
            check("cp_cnt", int'(fifo_cnt), 2);
            check("cp_wr_ptr", int'(dut.wr_ptr), m_wr);
            check("cp_rd_ptr", int'(dut.rd_ptr), m_rd);
        end
        drain();

        // Early tlast on a 256-element row.
        row_len = 12'd256;
        d = $urandom;
        beat(d, 1'b1);
        @(negedge clk);
        check("tlast_cnt", int'(fifo_cnt), 1);
        check("tlast_last", int'(m_row_last), 1);
        check("tlast_e5", elem(5), int'(d[5*ELEM_W +: ELEM_W]));
        check("tlast_e6", elem(6), 0);
        check("tlast_e255", elem(255), 0);
        drain();

        // Clear mid-row with two rows stored.
        row_len = 12'd6;
        beat($urandom, 1'b0);
        beat($urandom, 1'b0);
        row_len = 12'd12;
        beat($urandom, 1'b0);
        @(negedge clk);
        check("clear_pre_cnt", int'(fifo_cnt), 2);
        check("clear_pre_busy", int'(pack_busy), 1);
        clear         = 1'b1;
        s_axis_tdata  = $urandom;
        s_axis_tvalid = 1'b1;
        #1;
        check("clear_tready", int'(s_axis_tready), 0);
        model_flush();
        @(posedge clk);
        #1;
        clear         = 1'b0;
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        check("clear_cnt", int'(fifo_cnt), 0);
        check("clear_busy", int'(pack_busy), 0);
        check("clear_valid", int'(m_row_valid), 0);
        row_len = 12'd6;
        beat($urandom, 1'b0);
        @(negedge clk);
        check("clear_next_wr", int'(dut.wr_ptr), m_wr);
        check("clear_next_rd", int'(dut.rd_ptr), 0);
        check("clear_next_valid", int'(m_row_valid), 1);
        drain();

        // Asynchronous reset mid-row.
        beat($urandom, 1'b0);
        row_len = 12'd12;
        beat($urandom, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        model_flush();
        #1;
        check_reset("midreset");
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic: random lengths (including 0 and >MAC_NUM), tlast, gaps, pops.
        pop_mode = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            row_len = 12'($urandom_range(0, 300));
            beat($urandom, 1'($urandom_range(0, 9) == 0));
        end
        beat($urandom, 1'b1);
        drain();
        check("final_cnt", int'(fifo_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
